alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu_pkg.sv | 19 +
 rtl/alu_mdu_decode.sv | 61 ++++++
 rtl/alu_mdu.sv | 180 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared types for the ALU/MDU slice: alu_op class codes, internal op enum, FSM states.
package alu_mdu_pkg;

  localparam logic [2:0] ALU_OP_ADDR   = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;
  localparam logic [6:0] FUNCT7_MEXT   = 7'b0000001;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

endpackage

// File: rtl/alu_mdu_decode.sv
// Combinational {alu_op, funct3, funct7} -> op_e decoder.
// M-extension encodings decode only when ALU_MDU_M_EN is defined; otherwise they are illegal.
module alu_mdu_decode
  import alu_mdu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output op_e        op
);

  always_comb begin
    op = OP_ILLEGAL;
    case (alu_op)
      ALU_OP_ADDR: op = OP_ADD;
      ALU_OP_BRANCH: begin
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      ALU_OP_RTYPE, ALU_OP_ITYPE: begin
        if (alu_op == ALU_OP_RTYPE && funct7 == FUNCT7_MEXT) begin
`ifdef ALU_MDU_M_EN
          case (funct3)
            3'b000:  op = OP_MUL;
            3'b001:  op = OP_MULH;
            3'b010:  op = OP_MULHSU;
            3'b011:  op = OP_MULHU;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            default: op = OP_REMU;
          endcase
`else
          op = OP_ILLEGAL;
`endif
        end else begin
          case (funct3)
            // Immediates have no SUB form, so funct7[5] only selects SUB for R-type.
            3'b000:  op = (alu_op == ALU_OP_RTYPE && funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle RV32I-style ALU with optional iterative multiply/divide (macro ALU_MDU_M_EN).
// Handshake: a request transfers on in_valid && in_ready, a result on out_valid && out_ready.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_err,
  output logic            busy,
  output state_e          dbg_state
);

  localparam int SH_W = $clog2(XLEN);

  state_e          state_q, state_d, start_state;
  op_e             dec_op;
  logic            accept, iter_done;
  logic [XLEN-1:0] sc_res, one_res, it_res, result_q;
  logic            err_q;
  logic [SH_W-1:0] shamt;

  alu_mdu_decode u_decode (.alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op(dec_op));

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;
  assign out_err   = err_q;
  assign dbg_state = state_q;
  assign shamt     = op_b[SH_W-1:0];

  always_comb begin
    sc_res = '0;
    case (dec_op)
      OP_ADD:  sc_res = op_a + op_b;
      OP_SUB:  sc_res = op_a - op_b;
      OP_SLL:  sc_res = op_a << shamt;
      OP_SLT:  sc_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: sc_res = XLEN'(op_a < op_b);
      OP_XOR:  sc_res = op_a ^ op_b;
      OP_SRL:  sc_res = op_a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   sc_res = op_a | op_b;
      OP_AND:  sc_res = op_a & op_b;
      OP_BEQ:  sc_res = XLEN'(op_a == op_b);
      OP_BNE:  sc_res = XLEN'(op_a != op_b);
      OP_BLT:  sc_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_BGE:  sc_res = XLEN'($signed(op_a) >= $signed(op_b));
      OP_BLTU: sc_res = XLEN'(op_a < op_b);
      OP_BGEU: sc_res = XLEN'(op_a >= op_b);
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MDU_M_EN
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  hi_q, lo_q, m_q, hi_d, lo_d, mag_a, mag_b, mc_res;
  logic             neg_q, neg_d, a_neg, b_neg, is_mul, is_div, div_zero, div_ovf;
  logic [XLEN:0]    mul_sum, div_shift, div_diff;
  logic [2*XLEN:0]  mul_shift;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    is_mul   = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    a_neg    = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
    b_neg    = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    div_zero = (dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (op_b == '0);
    div_ovf  = (dec_op inside {OP_DIV, OP_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    is_div   = (dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && !div_zero && !div_ovf;
    // Remainder takes the dividend's sign; quotient and product take the xor.
    neg_d    = (dec_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    mc_res   = '0;
    if (div_zero)     mc_res = (dec_op inside {OP_DIV, OP_DIVU}) ? '1 : op_a;
    else if (div_ovf) mc_res = (dec_op == OP_DIV) ? op_a : '0;
    one_res     = (div_zero || div_ovf) ? mc_res : sc_res;
    start_state = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
  end

  // One iteration per cycle: shift-add multiply or restoring divide on magnitudes.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    mul_shift = {mul_sum, lo_q} >> 1;
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (state_q == S_MUL) begin
      hi_d = mul_shift[2*XLEN-1:XLEN];
      lo_d = mul_shift[XLEN-1:0];
    end else if (!div_diff[XLEN]) begin
      hi_d = div_diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    case (op_q)
      OP_MUL:              it_res = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:     it_res = neg_q ? -lo_d : lo_d;
      OP_REM, OP_REMU:     it_res = neg_q ? -hi_d : hi_d;
      default:             it_res = prod[2*XLEN-1:XLEN];
    endcase
    iter_done = busy && (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ADD;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      op_q  <= dec_op;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= is_mul ? mag_b : mag_a;
      m_q   <= is_mul ? mag_a : mag_b;
      neg_q <= neg_d;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end
`else
  assign one_res     = sc_res;
  assign it_res      = '0;
  assign iter_done   = 1'b0;
  assign start_state = S_DONE;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = start_state;
      S_MUL, S_DIV: if (iter_done) state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = start_state;
        else if (out_ready) state_d = S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && start_state == S_DONE) begin
        result_q <= one_res;
        err_q    <= (dec_op == OP_ILLEGAL);
      end else if (iter_done) begin
        result_q <= it_res;
        err_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (XLEN=32); expectations follow ALU_MDU_M_EN when defined.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [2:0]      alu_op, funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a, op_b, result;
  state_e          dbg_state;

  logic [XLEN:0] exp_q[$];
  int            lat_q[$];
  int            n_checks = 0;
  int            n_errs   = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_err(out_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: {err, result} and cycles from accept to out_valid.
  function automatic void model(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [32:0] exp, output int lat);
    logic [31:0] r;
    logic        e;
    int          sh;
`ifdef ALU_MDU_M_EN
    logic signed [63:0] sa, sb;
    logic [63:0]        p;
    logic               ovf;
`endif
    r = '0; e = 1'b0; lat = 1; sh = int'(b[4:0]);
    if (op == 3'b000) r = a + b;
    else if (op == 3'b001) begin
      case (f3)
        3'd0: r = {31'b0, a == b};
        3'd1: r = {31'b0, a != b};
        3'd4: r = {31'b0, $signed(a) < $signed(b)};
        3'd5: r = {31'b0, $signed(a) >= $signed(b)};
        3'd6: r = {31'b0, a < b};
        3'd7: r = {31'b0, a >= b};
        default: e = 1'b1;
      endcase
    end else if (op == 3'b010 && f7 == 7'b0000001) begin
`ifdef ALU_MDU_M_EN
      sa = $signed(a); sb = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      lat = 33;
      case (f3)
        3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: if (b == 0) begin r = '1; lat = 1; end
              else if (ovf) begin r = a; lat = 1; end
              else r = $signed(a) / $signed(b);
        3'd5: if (b == 0) begin r = '1; lat = 1; end else r = a / b;
        3'd6: if (b == 0) begin r = a; lat = 1; end
              else if (ovf) begin r = '0; lat = 1; end
              else r = $signed(a) % $signed(b);
        default: if (b == 0) begin r = a; lat = 1; end else r = a % b;
      endcase
`else
      e = 1'b1;
`endif
    end else if (op == 3'b010 || op == 3'b011) begin
      case (f3)
        3'd0: r = (op == 3'b010 && f7[5]) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = {31'b0, $signed(a) < $signed(b)};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: if (f7[5]) r = $signed(a) >>> sh; else r = a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else e = 1'b1;
    exp = {e, r};
  endfunction

  // Driver: present one request for one clock; the unit is idle whenever this is called.
  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    int          l;
    model(op, f3, f7, a, b, e, l);
    exp_q.push_back(e);
    lat_q.push_back(l);
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Monitor side: wait for out_valid, compare against the scoreboard, optionally stall, then consume.
  task automatic collect(input string tag, input int hold);
    int          n, nbusy;
    logic [32:0] e;
    int          l;
    n = 0; nbusy = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (busy) nbusy++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!out_valid) begin
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    check({tag, "_result"}, 64'(result), 64'(e[31:0]));
    check({tag, "_err"}, 64'(out_err), 64'(e[32]));
    check({tag, "_latency"}, 64'(n), 64'(l));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(l - 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, 64'(result), 64'(e[31:0]));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop, rf3;
    logic [6:0]  rf7;
    logic [31:0] ra, rb;
    int          k, seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_err", 64'(out_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed single-cycle cases
    send(3'b010, 3'b000, 7'b0100000, 32'd5, 32'd7);                collect("sub", 0);
    check("sub_value", 64'(result), 64'hFFFF_FFFE);
    send(3'b001, 3'b100, 7'b0, 32'hFFFF_FFFF, 32'd1);              collect("blt", 0);
    send(3'b001, 3'b110, 7'b0, 32'hFFFF_FFFF, 32'd1);              collect("bltu", 0);
    send(3'b100, 3'b000, 7'b0, 32'd9, 32'd9);                      collect("illegal_class", 0);
    send(3'b001, 3'b010, 7'b0, 32'd1, 32'd1);                      collect("illegal_branch", 0);
    send(3'b010, 3'b001, 7'b0, 32'h0000_0003, 32'd33);             collect("sll_wrap_shamt", 0);
    send(3'b011, 3'b101, 7'b0100000, 32'h8000_00F0, 32'd4);        collect("srai", 0);
    send(3'b011, 3'b000, 7'b0100000, 32'd10, 32'd3);               collect("addi_no_sub", 0);
    send(3'b000, 3'b000, 7'b0, 32'hFFFF_FFFF, 32'd2);              collect("add_wrap", 0);
    send(3'b010, 3'b000, 7'b0100000, 32'd10, 32'd3);               collect("stall", 5);

`ifdef ALU_MDU_M_EN
    send(3'b010, 3'b001, 7'b0000001, 32'h8000_0000, 32'h8000_0000); collect("mulh", 0);
    send(3'b010, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF); collect("div_ovf", 0);
    send(3'b010, 3'b101, 7'b0000001, 32'd7, 32'd0);                 collect("divu_zero", 0);
    send(3'b010, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2);         collect("rem_neg", 0);
    send(3'b010, 3'b010, 7'b0000001, 32'hFFFF_FFFE, 32'd3);         collect("mulhsu", 0);
    send(3'b010, 3'b000, 7'b0000001, 32'h1234_5678, 32'h9ABC_DEF1); collect("mul", 0);
`else
    send(3'b010, 3'b000, 7'b0000001, 32'd3, 32'd4);                 collect("mul_disabled", 0);
`endif

    // Reset in the middle of an operation (or while a result is pending) discards it.
`ifdef ALU_MDU_M_EN
    send(3'b010, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
`else
    send(3'b000, 3'b000, 7'b0, 32'd1, 32'd2);
    repeat (9) @(negedge clk);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
`endif
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    rst_n = 1'b0;
    #1;
    check("midop_reset_valid", 64'(out_valid), 64'd0);
    check("midop_reset_busy", 64'(busy), 64'd0);
    check("midop_reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_reset_no_result", 64'(seen), 64'd0);

    // Random mix through the scoreboard
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 1)      rop = 3'b000;
      else if (k < 3) rop = 3'b001;
      else if (k < 6) rop = 3'b010;
      else if (k < 9) rop = 3'b011;
      else            rop = 3'($urandom_range(4, 7));
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       rf7 = 7'b0000000;
        1:       rf7 = 7'b0100000;
        default: rf7 = 7'b0000001;
      endcase
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      send(rop, rf3, rf7, ra, rb);
      collect("rand", 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
